// File: rtl/sic1_pkg.sv
// Shared types for the SIC-1 memory subsystem: requester identity and the
// request word that the arbiter registers onto the memory port.
package sic1_pkg;

  localparam int SIC1_ADDR_W = 8;
  localparam int SIC1_DATA_W = 8;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic [SIC1_ADDR_W-1:0] addr;
    logic                   we;
    logic [SIC1_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sic1_rr_pick.sv
// Two-way grant picker: round-robin or fixed host priority, with a lockout
// input that removes the host from consideration entirely.
module sic1_rr_pick
  import sic1_pkg::*;
#(
  parameter bit HOST_PRIORITY = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       host_block,
  output logic [1:0] gnt
);

  logic [1:0] req_eff_s;

  // Grant decode; bit 0 is the CPU, bit 1 is the host.
  always_comb begin
    gnt       = 2'b00;
    req_eff_s = {req[1] & ~host_block, req[0]};
    case (req_eff_s)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (HOST_PRIORITY) begin
          gnt = 2'b10;
        end else if (last_owner == OWNER_HOST) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sic1_mem_arbiter.sv
// Shares the single-port SIC-1 memory between the subleq core and the host
// port; one registered access per cycle, reads return two cycles after grant.
module sic1_mem_arbiter
  import sic1_pkg::*;
#(
  parameter int ADDR_W        = SIC1_ADDR_W,
  parameter int DATA_W        = SIC1_DATA_W,
  parameter bit HOST_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              locked
);

  logic [1:0]        gnt_s;
  logic              cpu_acc_s;
  logic              host_acc_s;
  logic              acc_s;
  mem_req_t          sel_s;

  logic [ADDR_W-1:0] mem_addr_r;
  logic              mem_wr_en_r;
  logic [DATA_W-1:0] mem_data_in_r;
  owner_e            last_owner_r;
  logic              s1_valid_r;
  owner_e            s1_owner_r;
  logic              cpu_rvalid_r;
  logic              host_rvalid_r;
  logic              locked_r;

  sic1_rr_pick #(
    .HOST_PRIORITY(HOST_PRIORITY)
  ) u_pick (
    .req       ({host_req, cpu_req}),
    .last_owner(last_owner_r),
    .host_block(locked_r),
    .gnt       (gnt_s)
  );

  assign cpu_gnt    = gnt_s[0];
  assign host_gnt   = gnt_s[1];
  assign cpu_acc_s  = cpu_req & gnt_s[0];
  assign host_acc_s = host_req & gnt_s[1];
  assign acc_s      = cpu_acc_s | host_acc_s;

  // Select the winning requester's address/command/data.
  always_comb begin
    sel_s = '{addr: cpu_addr, we: cpu_we, wdata: cpu_wdata};
    if (host_acc_s) begin
      sel_s = '{addr: host_addr, we: host_we, wdata: host_wdata};
    end else begin
      sel_s = '{addr: cpu_addr, we: cpu_we, wdata: cpu_wdata};
    end
  end

  // Memory port, read pipeline, round-robin history and CPU lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_wr_en_r   <= 1'b0;
      mem_data_in_r <= {DATA_W{1'b0}};
      last_owner_r  <= OWNER_HOST;
      s1_valid_r    <= 1'b0;
      s1_owner_r    <= OWNER_CPU;
      cpu_rvalid_r  <= 1'b0;
      host_rvalid_r <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      if (acc_s) begin
        mem_addr_r    <= sel_s.addr;
        mem_wr_en_r   <= sel_s.we;
        mem_data_in_r <= sel_s.wdata;
        last_owner_r  <= host_acc_s ? OWNER_HOST : OWNER_CPU;
      end else begin
        mem_wr_en_r   <= 1'b0;
      end
      s1_valid_r    <= acc_s & ~sel_s.we;
      s1_owner_r    <= host_acc_s ? OWNER_HOST : OWNER_CPU;
      cpu_rvalid_r  <= s1_valid_r & (s1_owner_r == OWNER_CPU);
      host_rvalid_r <= s1_valid_r & (s1_owner_r == OWNER_HOST);
      // Dropping cpu_lock always wins; a lock only begins with an accepted CPU access.
      if (!cpu_lock) begin
        locked_r <= 1'b0;
      end else if (cpu_acc_s) begin
        locked_r <= 1'b1;
      end else begin
        locked_r <= locked_r;
      end
    end
  end

  assign mem_addr    = mem_addr_r;
  assign mem_wr_en   = mem_wr_en_r;
  assign mem_data_in = mem_data_in_r;
  assign locked      = locked_r;
  assign cpu_rvalid  = cpu_rvalid_r;
  assign host_rvalid = host_rvalid_r;
  // The memory's synchronous read output lines up with stage 2, so it is steered, not re-registered.
  assign cpu_rdata   = cpu_rvalid_r  ? mem_data_out : {DATA_W{1'b0}};
  assign host_rdata  = host_rvalid_r ? mem_data_out : {DATA_W{1'b0}};

endmodule

// File: tb/tb_sic1_mem_arbiter.sv
// Self-checking bench for sic1_mem_arbiter: a write-first memory model plus a
// read-return scoreboard, with one task per scenario.
module tb_sic1_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, cpu_lock;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_wr_en, locked;
  logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_data_in, mem_data_out;

  logic       hp_cpu_gnt, hp_cpu_rvalid, hp_host_gnt, hp_host_rvalid, hp_mem_wr_en, hp_locked;
  logic [7:0] hp_cpu_rdata, hp_host_rdata, hp_mem_addr, hp_mem_data_in;
  logic [7:0] hp_mem_data_out = 8'h00;

  logic [7:0] mem_arr [0:255];
  logic [7:0] ref_mem [0:255];

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t cpu_q[$];
  exp_t host_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sic1_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_PRIORITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .locked(locked)
  );

  sic1_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_PRIORITY(1'b1)) dut_hp (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_gnt(hp_cpu_gnt), .cpu_rvalid(hp_cpu_rvalid), .cpu_rdata(hp_cpu_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_gnt(hp_host_gnt), .host_rvalid(hp_host_rvalid), .host_rdata(hp_host_rdata),
    .mem_addr(hp_mem_addr), .mem_wr_en(hp_mem_wr_en), .mem_data_in(hp_mem_data_in),
    .mem_data_out(hp_mem_data_out), .locked(hp_locked)
  );

  // Write-first synchronous memory
  always @(posedge clk) begin
    if (mem_wr_en) mem_arr[mem_addr] <= mem_data_in;
    mem_data_out <= mem_wr_en ? mem_data_in : mem_arr[mem_addr];
  end

  // Scoreboard: check returns due this cycle, then record this cycle's acceptances
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      cpu_q.delete();
      host_q.delete();
    end else begin
      n_checks++;
      if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
        e = cpu_q.pop_front();
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== e.data)
          $display("FAIL cpu_return cyc=%0d: rvalid=%0b rdata=%02h, expected rvalid=1 rdata=%02h", cyc, cpu_rvalid, cpu_rdata, e.data);
        else n_pass++;
      end else if (cpu_rvalid !== 1'b0)
        $display("FAIL cpu_rvalid_spurious cyc=%0d: rvalid=%0b, expected 0", cyc, cpu_rvalid);
      else n_pass++;

      n_checks++;
      if (host_q.size() > 0 && host_q[0].due == cyc) begin
        e = host_q.pop_front();
        if (host_rvalid !== 1'b1 || host_rdata !== e.data)
          $display("FAIL host_return cyc=%0d: rvalid=%0b rdata=%02h, expected rvalid=1 rdata=%02h", cyc, host_rvalid, host_rdata, e.data);
        else n_pass++;
      end else if (host_rvalid !== 1'b0)
        $display("FAIL host_rvalid_spurious cyc=%0d: rvalid=%0b, expected 0", cyc, host_rvalid);
      else n_pass++;

      n_checks++;
      if ((cpu_gnt && host_gnt) || (cpu_gnt && !cpu_req) || (host_gnt && !host_req) || (host_gnt && locked))
        $display("FAIL gnt_legal cyc=%0d: cpu_gnt=%0b host_gnt=%0b cpu_req=%0b host_req=%0b locked=%0b, expected legal grant", cyc, cpu_gnt, host_gnt, cpu_req, host_req, locked);
      else n_pass++;

      if (cpu_req && cpu_gnt) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else cpu_q.push_back('{cyc + 2, ref_mem[cpu_addr]});
      end
      if (host_req && host_gnt) begin
        if (host_we) ref_mem[host_addr] = host_wdata;
        else host_q.push_back('{cyc + 2, ref_mem[host_addr]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 8'h00 || mem_wr_en !== 1'b0 || mem_data_in !== 8'h00 || locked !== 1'b0 ||
        cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || host_rdata !== 8'h00)
      $display("FAIL reset_state: addr=%02h we=%0b din=%02h locked=%0b rv=%0b/%0b rd=%02h/%02h, expected all 0",
               mem_addr, mem_wr_en, mem_data_in, locked, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_host_only();
    step(); host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
    @(negedge clk);
    n_checks++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0)
      $display("FAIL host_write_gnt: host_gnt=%0b cpu_gnt=%0b, expected 1/0", host_gnt, cpu_gnt);
    else n_pass++;
    step(); host_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 8'h10 || mem_data_in !== 8'h5A || host_gnt !== 1'b1)
      $display("FAIL host_write_port: we=%0b addr=%02h din=%02h gnt=%0b, expected 1/10/5a/1", mem_wr_en, mem_addr, mem_data_in, host_gnt);
    else n_pass++;
    step(); idle();
    @(negedge clk);
    n_checks++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 8'h10)
      $display("FAIL host_read_port: we=%0b addr=%02h, expected 0/10", mem_wr_en, mem_addr);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h5A || cpu_rvalid !== 1'b0)
      $display("FAIL host_read_data: rvalid=%0b rdata=%02h cpu_rvalid=%0b, expected 1/5a/0", host_rvalid, host_rdata, cpu_rvalid);
    else n_pass++;
    repeat (2) step();
  endtask

  task automatic test_contention();
    logic exp_cpu;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h11;
      @(negedge clk);
      exp_cpu = (i % 2 == 0);
      n_checks++;
      if (cpu_gnt !== exp_cpu || host_gnt !== !exp_cpu)
        $display("FAIL rr_alternate i=%0d: cpu_gnt=%0b host_gnt=%0b, expected %0b/%0b", i, cpu_gnt, host_gnt, exp_cpu, !exp_cpu);
      else n_pass++;
    end
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_lock();
    do_reset();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20; cpu_lock = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0)
      $display("FAIL lock_first: cpu_gnt=%0b host_gnt=%0b, expected 1/0", cpu_gnt, host_gnt);
    else n_pass++;
    step(); cpu_addr = 8'h21;
    @(negedge clk);
    n_checks++;
    if (locked !== 1'b1 || cpu_gnt !== 1'b1 || host_gnt !== 1'b0)
      $display("FAIL lock_read_b: locked=%0b cpu_gnt=%0b host_gnt=%0b, expected 1/1/0", locked, cpu_gnt, host_gnt);
    else n_pass++;
    step(); cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h03;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0)
      $display("FAIL lock_store: cpu_gnt=%0b host_gnt=%0b, expected 1/0", cpu_gnt, host_gnt);
    else n_pass++;
    step(); cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0;
    @(negedge clk);
    n_checks++;
    if (locked !== 1'b1 || host_gnt !== 1'b0)
      $display("FAIL lock_drop_cycle: locked=%0b host_gnt=%0b, expected 1/0", locked, host_gnt);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if (locked !== 1'b0 || host_gnt !== 1'b1)
      $display("FAIL lock_release: locked=%0b host_gnt=%0b, expected 0/1", locked, host_gnt);
    else n_pass++;
    step(); host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 8'h20 || mem_data_in !== 8'hFF)
      $display("FAIL lock_host_write: we=%0b addr=%02h din=%02h, expected 1/20/ff", mem_wr_en, mem_addr, mem_data_in);
    else n_pass++;
    step(); host_req = 1'b1; host_addr = 8'h20;
    step(); idle();
    step();
    @(negedge clk);
    n_checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'hFF || mem_arr[8'h20] !== 8'hFF)
      $display("FAIL lock_final: rvalid=%0b rdata=%02h mem=%02h, expected 1/ff/ff", host_rvalid, host_rdata, mem_arr[8'h20]);
    else n_pass++;
    repeat (2) step();
  endtask

  task automatic test_host_priority();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      cpu_req = 1'b1; cpu_addr = 8'h40; host_req = 1'b1; host_addr = 8'h41;
      @(negedge clk);
      n_checks++;
      if (hp_host_gnt !== 1'b1 || hp_cpu_gnt !== 1'b0)
        $display("FAIL prio_host i=%0d: host_gnt=%0b cpu_gnt=%0b, expected 1/0", i, hp_host_gnt, hp_cpu_gnt);
      else n_pass++;
    end
    step(); host_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hp_cpu_gnt !== 1'b1 || hp_host_gnt !== 1'b0)
      $display("FAIL prio_cpu_after: cpu_gnt=%0b host_gnt=%0b, expected 1/0", hp_cpu_gnt, hp_host_gnt);
    else n_pass++;
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_reset_mid_read();
    step(); host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    @(negedge clk);
    n_checks++;
    if (host_gnt !== 1'b1)
      $display("FAIL midrst_gnt: host_gnt=%0b, expected 1", host_gnt);
    else n_pass++;
    step(); rst_n = 1'b0; host_req = 1'b0;
    step(); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 8'h00 || mem_wr_en !== 1'b0 || mem_data_in !== 8'h00 || host_rvalid !== 1'b0)
      $display("FAIL midrst_state: addr=%02h we=%0b din=%02h rvalid=%0b, expected 0/0/0/0", mem_addr, mem_wr_en, mem_data_in, host_rvalid);
    else n_pass++;
    step();
    cpu_req = 1'b1; cpu_addr = 8'h31; host_req = 1'b1; host_addr = 8'h32;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0)
      $display("FAIL midrst_tie: cpu_gnt=%0b host_gnt=%0b, expected 1/0", cpu_gnt, host_gnt);
    else n_pass++;
    step(); idle();
    repeat (3) step();
  endtask

  task automatic test_back_to_back();
    step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h01; cpu_wdata = 8'h07;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt !== 1'b1)
      $display("FAIL b2b_write_gnt: cpu_gnt=%0b, expected 1", cpu_gnt);
    else n_pass++;
    step(); cpu_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt !== 1'b1)
      $display("FAIL b2b_read_gnt: cpu_gnt=%0b, expected 1", cpu_gnt);
    else n_pass++;
    step(); idle();
    step();
    @(negedge clk);
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h07)
      $display("FAIL b2b_read_data: rvalid=%0b rdata=%02h, expected 1/07", cpu_rvalid, cpu_rdata);
    else n_pass++;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_host_only();
    test_contention();
    test_lock();
    test_host_priority();
    test_reset_mid_read();
    test_back_to_back();
    n_checks++;
    if (cpu_q.size() != 0 || host_q.size() != 0)
      $display("FAIL drain: cpu_q=%0d host_q=%0d outstanding, expected 0/0", cpu_q.size(), host_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sic1_mem_arbiter.md
Name: sic1_mem_arbiter

Overview:
Two-requester arbiter sharing the single-port 256x8 SIC-1 memory between the subleq core and the host loader/debug port. It accepts valid/grant transactions from both sides and registers one access per cycle onto the memory port. Read data is routed back to the issuing requester with a fixed latency. A CPU lock keeps the core's read-mem-A → read-mem-B → store sequence atomic against host writes.

Parameters:
ADDR_W, 8, address width (memory depth 2**ADDR_W)
DATA_W, 8, data width
HOST_PRIORITY, 0, 0 = round-robin on contention; 1 = host always wins unless locked out

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
cpu_req  in  1  CPU transaction request
cpu_addr  in  ADDR_W  CPU address
cpu_we  in  1  1 = write, 0 = read
cpu_wdata  in  DATA_W  CPU write data
cpu_lock  in  1  CPU requests exclusive access
cpu_gnt  out  1  CPU transaction accepted this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
host_req  in  1  host transaction request
host_addr  in  ADDR_W  host address
host_we  in  1  1 = write, 0 = read
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host transaction accepted this cycle (combinational)
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_W  host read data
mem_addr  out  ADDR_W  memory address (registered)
mem_wr_en  out  1  memory write strobe (registered)
mem_data_in  out  DATA_W  memory write data (registered)
mem_data_out  in  DATA_W  memory read data; synchronous read, valid 1 cycle after mem_addr
locked  out  1  lock currently held by CPU (status)

Behaviour:
- Reset is synchronous on rst_n=0. The following outputs clear to 0: mem_addr, mem_wr_en, mem_data_in, locked, both rvalid, both rdata, the pipeline valid/owner bits, and last_owner (reset value = HOST, so the CPU wins the first tie).
- Reset mid-transaction discards in-flight reads. No rvalid is issued after reset.
- Grant (combinational, cycle N):
  - Only one requester is pending: it is granted, unless it is the host while locked=1.
  - Both pending, HOST_PRIORITY=0: grant the requester opposite last_owner.
  - Both pending, HOST_PRIORITY=1: grant the host.
  - locked=1 forces host_gnt=0 in every case.
  - At most one gnt is high per cycle. A gnt is never asserted without its req.
- Acceptance means req & gnt at the clock edge ending cycle N. On acceptance:
  - mem_addr, mem_wr_en (= we) and mem_data_in are registered and driven during cycle N+1.
  - last_owner is updated.
  - Stage-1 valid/owner is set for reads only.
- mem_wr_en is high for exactly one cycle per accepted write.
- Idle cycles: mem_wr_en=0 and mem_addr holds its last value.
- Read return: stage 1 advances to stage 2. In cycle N+2 the owner's rvalid=1 and rdata=mem_data_out, registered from the N+1 edge. Read latency is exactly 2 cycles after acceptance. The non-owner's rvalid stays 0.
- Throughput is one access per cycle, back-to-back. Reads and writes may interleave freely. Returns never reorder.
- Lock:
  - locked is set at the edge that accepts a CPU transaction with cpu_lock=1.
  - locked is cleared at any edge where cpu_lock=0, and that clear takes effect the following cycle.
  - cpu_lock=1 while not locked, with no accepted CPU transaction, has no effect.
- Write-then-read to the same address on consecutive cycles returns the new data; the memory is write-first and no bypass is required.
- Addresses use the full range 0..2**ADDR_W-1. There is no wrap logic, since addressing is the requester's job.

Decomposition:
- Package sic1_pkg holds: owner enum (OWNER_CPU, OWNER_HOST), ADDR_W/DATA_W defaults, and the shared memory-request struct (addr, we, wdata).
- Sub-module sic1_rr_pick is a 2-way round-robin/priority picker: inputs req[1:0], last_owner, host_block; outputs gnt[1:0]. Everything else stays in the top.

Test Plan:
- Host only: write 0x5A to 0x10, then read 0x10 → mem_wr_en=1 one cycle later with mem_addr=0x10; host_rvalid=1 with host_rdata=0x5A two cycles after the read grant; cpu_rvalid stays 0.
- Contention, HOST_PRIORITY=0, both reading continuously from reset → grants alternate CPU, HOST, CPU, HOST; each rvalid appears 2 cycles after its own grant; no cycle has both gnt high.
- Lock: CPU reads 0x20 with cpu_lock=1, host write-requests 0x20=0xFF; CPU reads 0x21 then writes 0x20=0x03, then drops lock → host_gnt=0 throughout the locked period; the host write is granted the cycle after cpu_lock falls; final mem[0x20]=0xFF.
- HOST_PRIORITY=1 with both requesting for 4 cycles → host granted all 4, cpu_gnt=0; CPU granted on the first cycle host_req=0.
- Reset mid-read: host read granted, rst_n=0 on the next edge → no host_rvalid afterwards; all mem outputs 0; the first post-reset tie is granted to the CPU.
- Back-to-back: CPU writes 0x01=0x07, then immediately reads 0x01 → cpu_rdata=0x07 with cpu_rvalid two cycles after the read grant.
